// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the VGA timing generator and its pixel source.
// master: generator side (takes en/rgb_in, drives req/x/y/frame_start);
// slave: pixel source side.
interface vga_timing_gen_if;
    logic        en;
    logic [23:0] rgb_in;
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_start;

    modport master (
        input  en,
        input  rgb_in,
        output req,
        output x,
        output y,
        output frame_start
    );

    modport slave (
        output en,
        output rgb_in,
        input  req,
        input  x,
        input  y,
        input  frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock = CLOCK_50/2, h/v counters,
// registered active-low syncs, blank and colour aligned one tick after req.
// Ports: CLOCK_50, RST_N (async, active low), pix (en, rgb_in, req, x, y,
// frame_start), VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R/G/B.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic                    CLOCK_50,
    input  logic                    RST_N,
    vga_timing_gen_if.master        pix,
    output logic                    VGA_CLK,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    VGA_BLANK_N,
    output logic                    VGA_SYNC_N,
    output logic [7:0]              VGA_R,
    output logic [7:0]              VGA_G,
    output logic [7:0]              VGA_B
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);

    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic       div;
    logic       tick;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       active;
    logic       hs_raw;
    logic       vs_raw;

    // The divider flop doubles as the pixel clock and the tick enable.
    assign tick    = div;
    assign VGA_CLK = div;

    assign active = (hc < H_ACT) && (vc < V_ACT);
    assign hs_raw = !((hc >= HS_BEG) && (hc < HS_END));
    assign vs_raw = !((vc >= VS_BEG) && (vc < VS_END));

    assign pix.x           = hc;
    assign pix.y           = vc;
    assign pix.req         = tick & pix.en & active;
    assign pix.frame_start = tick & pix.en & (hc == '0) & (vc == '0);

    assign VGA_SYNC_N = 1'b0;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            div         <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            div <= ~div;
            // Idle clears on any edge so a dropped en takes effect at once.
            if (!pix.en) begin
                hc          <= '0;
                vc          <= '0;
                VGA_HS      <= 1'b1;
                VGA_VS      <= 1'b1;
                VGA_BLANK_N <= 1'b0;
                VGA_R       <= '0;
                VGA_G       <= '0;
                VGA_B       <= '0;
            end else if (tick) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
                VGA_HS      <= hs_raw;
                VGA_VS      <= vs_raw;
                VGA_BLANK_N <= active;
                if (pix.req) begin
                    {VGA_R, VGA_G, VGA_B} <= pix.rgb_in;
                end else begin
                    {VGA_R, VGA_G, VGA_B} <= '0;
                end
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 H_ACTIVE, default 640, visible pixels per line.
REQ-002 H_FP, default 16; H_SYNC, default 96; H_BP, default 48; horizontal porch and sync widths in pixels.
REQ-003 V_ACTIVE, default 480, visible lines per frame.
REQ-004 V_FP, default 10; V_SYNC, default 2; V_BP, default 33; vertical porch and sync widths in lines.
REQ-005 CLOCK_50  in  1  system clock, 50 MHz; the only clock in the block.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  scan enable; low holds the raster idle.
REQ-008 rgb_in  in  24  pixel colour {R[7:0],G[7:0],B[7:0]} for the pixel currently requested.
REQ-009 req  out  1  high on a pixel tick whose (x,y) lies in the active area.
REQ-010 x  out  10  horizontal counter value; y  out  10  vertical counter value.
REQ-011 frame_start  out  1  one-CLOCK_50 pulse on the tick where x=0 and y=0.
REQ-012 VGA_CLK  out  1  pixel clock, CLOCK_50/2.
REQ-013 VGA_HS, VGA_VS  out  1 each  active-low sync.
REQ-014 VGA_BLANK_N  out  1  low outside the active area; VGA_SYNC_N  out  1  tied 0.
REQ-015 VGA_R, VGA_G, VGA_B  out  8 each  registered colour.

Function
REQ-016 A divider flop SHALL toggle on every CLOCK_50 rising edge; VGA_CLK SHALL equal that flop.
REQ-017 A pixel tick SHALL be the CLOCK_50 cycle in which the divider flop is 1.
REQ-018 On each tick, hc SHALL increment modulo H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
REQ-019 When hc wraps from H_TOTAL-1 to 0, vc SHALL increment modulo V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-020 Counters SHALL change only on ticks.
REQ-021 x SHALL be hc and y SHALL be vc, combinationally.
REQ-022 req SHALL be tick AND en AND hc<H_ACTIVE AND vc<V_ACTIVE.
REQ-023 frame_start SHALL be tick AND en AND hc=0 AND vc=0.
REQ-024 Horizontal sync raw SHALL be low for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751 by default.
REQ-025 Vertical sync raw SHALL be low for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491 by default.
REQ-026 On each tick, the block SHALL register VGA_HS, VGA_VS and VGA_BLANK_N from the raw values.
REQ-027 On each tick, the block SHALL register VGA_R/G/B from rgb_in when req is high and 0 otherwise.
REQ-028 Colour, syncs and blank SHALL therefore appear exactly one tick (2 CLOCK_50 cycles) after req, mutually aligned.
REQ-029 Registered outputs SHALL hold their value between ticks.
REQ-030 While en=0: hc=vc=0, req=0, frame_start=0, VGA_HS=VGA_VS=1, VGA_BLANK_N=0, RGB=0; VGA_CLK keeps toggling.
REQ-031 en falling mid-frame SHALL clear the counters at the next CLOCK_50 edge.
REQ-032 en rising SHALL start the scan at hc=0, vc=0 on the first subsequent tick, with frame_start asserted on that tick.
REQ-033 On the last tick of a frame (hc=799, vc=524) the next tick SHALL give hc=0, vc=0 and frame_start=1.

Reset
REQ-034 RST_N low SHALL immediately force: divider=0, VGA_CLK=0, hc=vc=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
REQ-035 During reset, req=0 and frame_start=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame.
REQ-037 After RST_N deasserts with en=1, the first tick SHALL occur on the second CLOCK_50 edge, with frame_start=1.

Verification
REQ-038 Reset, then en=1 for 2 frames -> 800x525 ticks per frame (840000 CLOCK_50 cycles); frame_start once per frame; VGA_CLK period 2 cycles.
REQ-039 Count ticks per line -> VGA_HS low for exactly 96 ticks starting the tick after hc=656; VGA_BLANK_N high for 640 ticks per active line.
REQ-040 Count lines per frame -> VGA_VS low for exactly 2 lines (vc 490..491, delayed one tick); 480 lines contain req pulses; 307200 req pulses per frame.
REQ-041 Drive rgb_in={x[7:0],y[7:0],8'hA5} -> each RGB sample equals the values from the previous req tick; RGB=0 whenever VGA_BLANK_N=0.
REQ-042 Drop en at hc=300, vc=100, then re-raise it 10 cycles later -> outputs go idle per REQ-030; scan restarts at (0,0) with frame_start.
REQ-043 Assert RST_N low at hc=700, vc=491 (VS low) -> VGA_VS=1, VGA_HS=1, RGB=0 immediately, with no wait for a clock edge.
